// File: rtl/rx_fifo_read_sched.sv
// Read-side scheduler for the UART receive FIFO.
// Shares the single FIFO read port between the host and the BIST checker
// with round-robin arbitration. For each granted read it pulses Read_Done,
// captures FIFO_Data a fixed latency later and presents the byte over the
// owner's valid/ack handshake. Unacknowledged bytes are dropped after a
// timeout, and a sticky error flag records the drop.
// BIST_Mode blocks FIFO writes while the BIST checker owns the read path.
// A separate saturating counter tallies FIFO overflow events.

module rx_fifo_read_sched #(
   parameter int DATA_BITS   = 8,
   parameter int CAP_LAT     = 2,
   parameter int ACK_TIMEOUT = 255,
   parameter int OVF_BITS    = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 FIFO_Empty,
   input  logic                 FIFO_Overflow,
   input  logic [DATA_BITS-1:0] FIFO_Data,
   output logic                 Read_Done,
   output logic                 BIST_Mode,
   input  logic                 Host_Req,
   output logic                 Host_Valid,
   output logic [DATA_BITS-1:0] Host_Data,
   input  logic                 Host_Ack,
   input  logic                 Bist_Req,
   output logic                 Bist_Valid,
   output logic [DATA_BITS-1:0] Bist_Data,
   input  logic                 Bist_Ack,
   output logic                 Drop_Err,
   output logic [OVF_BITS-1:0]  Ovf_Count
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      CAPTURE,
      DELIVER
   } state_t;

   state_t             state;
   logic               owner_bist;
   logic               last_bist;
   logic [2:0]         cap_cnt;
   logic [TMR_W-1:0]   tmr;
   logic               ovf_prev;

   logic               grant_bist;
   logic               cap_done;
   logic               owner_ack;
   logic               timed_out;

   // Arbitration and transaction-progress decodes shared by the FSM below
   always_comb begin
      grant_bist = Bist_Req && (!Host_Req || !last_bist);
      cap_done   = ((state == STROBE) && (CAP_LAT == 1)) ||
                   ((state == CAPTURE) && (cap_cnt == 3'(CAP_LAT - 1)));
      owner_ack  = owner_bist ? Bist_Ack : Host_Ack;
      timed_out  = (tmr == TMR_W'(ACK_TIMEOUT - 1));
   end

   // Read-transaction FSM with all handshake outputs registered
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         owner_bist <= 1'b0;
         last_bist  <= 1'b1;
         cap_cnt    <= '0;
         tmr        <= '0;
         Read_Done  <= 1'b0;
         BIST_Mode  <= 1'b0;
         Host_Valid <= 1'b0;
         Host_Data  <= '0;
         Bist_Valid <= 1'b0;
         Bist_Data  <= '0;
         Drop_Err   <= 1'b0;
      end else begin
         Read_Done <= 1'b0;
         case (state)
            IDLE: begin
               if (!Bist_Req) begin
                  BIST_Mode <= 1'b0;
               end
               if (!FIFO_Empty && (Host_Req || Bist_Req)) begin
                  owner_bist <= grant_bist;
                  if (grant_bist) begin
                     BIST_Mode <= 1'b1;
                  end
                  Read_Done <= 1'b1;
                  state     <= STROBE;
               end
            end
            STROBE: begin
               cap_cnt <= 3'd1;
               state   <= CAPTURE;
            end
            CAPTURE: begin
               cap_cnt <= cap_cnt + 3'd1;
            end
            DELIVER: begin
               if (owner_ack || timed_out) begin
                  Host_Valid <= 1'b0;
                  Bist_Valid <= 1'b0;
                  state      <= IDLE;
                  if (owner_bist && !Bist_Req) begin
                     BIST_Mode <= 1'b0;
                  end
                  if (owner_ack) begin
                     last_bist <= owner_bist;
                  end else begin
                     Drop_Err <= 1'b1;
                  end
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (cap_done) begin
            tmr   <= '0;
            state <= DELIVER;
            if (owner_bist) begin
               Bist_Data  <= FIFO_Data;
               Bist_Valid <= 1'b1;
            end else begin
               Host_Data  <= FIFO_Data;
               Host_Valid <= 1'b1;
            end
         end
      end
   end

   // Saturating count of FIFO_Overflow rising edges
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ovf_prev  <= 1'b0;
         Ovf_Count <= '0;
      end else begin
         ovf_prev <= FIFO_Overflow;
         if (FIFO_Overflow && !ovf_prev && (Ovf_Count != {OVF_BITS{1'b1}})) begin
            Ovf_Count <= Ovf_Count + 1'b1;
         end
      end
   end

endmodule
